// File: rtl/reg_access_ctrl.sv
// reg_access_ctrl: initiator-side controller for a 4-entry register file.
// Accepts one decoded operation at a time, reads both source operands,
// hands them to the datapath over a valid/ready handshake, collects the
// result and optionally writes it back with a single-cycle REG_WRITE.
//
// Optional feature macro: REG_ACCESS_ZERO_REG_EN
//   defined   -> register 0 reads as zero and is never written
//   undefined -> register 0 is an ordinary general-purpose register

package reg_access_pkg;

  // Register-file entry select.
  typedef enum logic [1:0] {
    REG_0 = 2'd0,
    REG_1 = 2'd1,
    REG_2 = 2'd2,
    REG_3 = 2'd3
  } register_sel_e;

  // Register-file operation; anything other than REG_WRITE leaves it unchanged.
  typedef enum logic {
    REG_READ  = 1'b0,
    REG_WRITE = 1'b1
  } registers_op_e;

endpackage

module reg_access_ctrl
  import reg_access_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,

  // decoder request
  input  logic                      req_valid,
  output logic                      req_ready,
  input  register_sel_e             req_src1,
  input  register_sel_e             req_src2,
  input  register_sel_e             req_dst,
  input  logic                      req_wb,

  // register file control
  output registers_op_e             reg_op,
  output register_sel_e             reg_in_sel,
  output register_sel_e             reg_1_out_sel,
  output register_sel_e             reg_2_out_sel,
  output logic [DATA_BUS_WIDTH-1:0] reg_data_in,
  input  logic [DATA_BUS_WIDTH-1:0] reg_1_out,
  input  logic [DATA_BUS_WIDTH-1:0] reg_2_out,

  // operands to the datapath
  output logic                      opnd_valid,
  input  logic                      opnd_ready,
  output logic [DATA_BUS_WIDTH-1:0] opnd_a,
  output logic [DATA_BUS_WIDTH-1:0] opnd_b,

  // result from the datapath
  input  logic                      res_valid,
  output logic                      res_ready,
  input  logic [DATA_BUS_WIDTH-1:0] res_data,

  output logic                      busy
);

`ifdef REG_ACCESS_ZERO_REG_EN
  localparam bit ZERO_REG_EN = 1'b1;
`else
  localparam bit ZERO_REG_EN = 1'b0;
`endif

  // FSM encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_READ   = 3'd1;
  localparam logic [2:0] ST_ISSUE  = 3'd2;
  localparam logic [2:0] ST_RESULT = 3'd3;
  localparam logic [2:0] ST_WRITE  = 3'd4;

  logic [2:0]                state_reg;
  logic [2:0]                state_next;

  // latched request fields
  register_sel_e             src1_reg;
  register_sel_e             src2_reg;
  register_sel_e             dst_reg;
  logic                      wb_reg;

  logic [DATA_BUS_WIDTH-1:0] result_reg;

  // both read ports handled uniformly: index 0 -> operand A, index 1 -> operand B
  register_sel_e             rd_sel     [2];
  logic [DATA_BUS_WIDTH-1:0] rd_data    [2];
  logic [DATA_BUS_WIDTH-1:0] opnd_reg   [2];
  logic [DATA_BUS_WIDTH-1:0] opnd_next  [2];

  logic                      accept_req;
  logic                      opnd_xfer;
  logic                      res_xfer;
  logic                      write_back;

  assign accept_req = (state_reg == ST_IDLE)   && req_valid;
  assign opnd_xfer  = (state_reg == ST_ISSUE)  && opnd_ready;
  assign res_xfer   = (state_reg == ST_RESULT) && res_valid;

  // A write to the hardwired zero register is silently dropped, so the
  // FSM skips WRITE entirely and reg_op never pulses for register 0.
  assign write_back = wb_reg && !(ZERO_REG_EN && (dst_reg == REG_0));

  assign rd_sel[0]  = src1_reg;
  assign rd_sel[1]  = src2_reg;
  assign rd_data[0] = reg_1_out;
  assign rd_data[1] = reg_2_out;

  // State register; reset forces IDLE at once so reg_op cannot finish a write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: one operation in flight, requests outside IDLE are ignored.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          state_next = ST_READ;
        end
      end
      ST_READ: begin
        state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (opnd_ready) begin
          state_next = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (res_valid) begin
          state_next = write_back ? ST_WRITE : ST_IDLE;
        end
      end
      ST_WRITE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Latch the request fields when a request is accepted in IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      src1_reg <= REG_0;
      src2_reg <= REG_0;
      dst_reg  <= REG_0;
      wb_reg   <= 1'b0;
    end else if (accept_req) begin
      src1_reg <= req_src1;
      src2_reg <= req_src2;
      dst_reg  <= req_dst;
      wb_reg   <= req_wb;
    end
  end

  // Operand capture, one instance per read port. Operands are sampled at the
  // end of READ and then held untouched through ISSUE, so they stay stable
  // until the datapath takes them.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      // Register 0 reads as zero when the hardwired-zero option is built in.
      always_comb begin
        opnd_next[gi] = rd_data[gi];
        if (ZERO_REG_EN && (rd_sel[gi] == REG_0)) begin
          opnd_next[gi] = '0;
        end
      end

      // Capture the operand at the READ -> ISSUE edge.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          opnd_reg[gi] <= '0;
        end else if (state_reg == ST_READ) begin
          opnd_reg[gi] <= opnd_next[gi];
        end
      end
    end
  endgenerate

  // Capture the datapath result on the result handshake; for wb=0 the value
  // is simply never written back.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result_reg <= '0;
    end else if (res_xfer) begin
      result_reg <= res_data;
    end
  end

  // Outputs are decoded straight from the state register so that an
  // asynchronous reset removes REG_WRITE in the same cycle.
  assign req_ready     = (state_reg == ST_IDLE);
  assign busy          = (state_reg != ST_IDLE);
  assign opnd_valid    = (state_reg == ST_ISSUE);
  assign res_ready     = (state_reg == ST_RESULT);
  assign reg_op        = (state_reg == ST_WRITE) ? REG_WRITE : REG_READ;

  assign reg_in_sel    = dst_reg;
  assign reg_1_out_sel = src1_reg;
  assign reg_2_out_sel = src2_reg;
  assign reg_data_in   = result_reg;

  assign opnd_a        = opnd_reg[0];
  assign opnd_b        = opnd_reg[1];

endmodule
